// File: rtl/mvb_rr_arbiter_if.sv
// MVB arbiter bus bundle: RX_PORTS input streams in, one registered stream with source index out.
interface mvb_rr_arbiter_if #(
  parameter int RX_PORTS   = 4,
  parameter int ITEMS      = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_W = $clog2(RX_PORTS);

  logic [RX_PORTS-1:0][ITEMS-1:0][DATA_WIDTH-1:0] rx_data;
  logic [RX_PORTS-1:0][ITEMS-1:0]                 rx_vld;
  logic [RX_PORTS-1:0]                            rx_src_rdy;
  logic [RX_PORTS-1:0]                            rx_dst_rdy;
  logic [ITEMS-1:0][DATA_WIDTH-1:0]               tx_data;
  logic [ITEMS-1:0]                               tx_vld;
  logic [SEL_W-1:0]                               tx_sel;
  logic                                           tx_src_rdy;
  logic                                           tx_dst_rdy;

  modport slave (
    input  rx_data, rx_vld, rx_src_rdy, tx_dst_rdy,
    output rx_dst_rdy, tx_data, tx_vld, tx_sel, tx_src_rdy
  );
  modport master (
    output rx_data, rx_vld, rx_src_rdy, tx_dst_rdy,
    input  rx_dst_rdy, tx_data, tx_vld, tx_sel, tx_src_rdy
  );
endinterface

// File: rtl/mvb_rr_arbiter.sv
// Round-robin MVB arbiter with optional burst lock and a registered output word.
// Optional: MVB_RR_ARB_DROP_EMPTY_EN acknowledges all-invalid words without forwarding them.
module mvb_rr_arbiter #(
  parameter int RX_PORTS   = 4,
  parameter int ITEMS      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 1
)(
  input logic              clk,
  input logic              reset,
  mvb_rr_arbiter_if.slave  bus
);
  localparam int SEL_W = $clog2(RX_PORTS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
`ifdef MVB_RR_ARB_DROP_EMPTY_EN
  localparam bit DROP_EMPTY = 1'b1;
`else
  localparam bit DROP_EMPTY = 1'b0;
`endif

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr, lock_port, gnt_idx, scan_base, idx;
  logic [CNT_W-1:0] burst_cnt, cnt_inc;
  logic             accept, gnt_vld, lock_hold, xfer, empty, wr;
  int               s;

  function automatic logic [SEL_W-1:0] nxt(input logic [SEL_W-1:0] p);
    return (p == SEL_W'(RX_PORTS - 1)) ? '0 : p + SEL_W'(1);
  endfunction

  assign accept    = !bus.tx_src_rdy | bus.tx_dst_rdy;
  assign lock_hold = (state == LOCK) & bus.rx_src_rdy[lock_port];
  assign scan_base = (state == LOCK) ? nxt(lock_port) : ptr;

  // Scan downwards so the port closest to scan_base is assigned last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    s       = 0;
    idx     = '0;
    if (lock_hold) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_port;
    end else begin
      for (int i = RX_PORTS - 1; i >= 0; i--) begin
        s = int'(scan_base) + i;
        if (s >= RX_PORTS) s = s - RX_PORTS;
        idx = SEL_W'(s);
        if (bus.rx_src_rdy[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    end
  end

  assign xfer    = gnt_vld & accept & !reset;
  assign empty   = (bus.rx_vld[gnt_idx] == '0);
  assign wr      = xfer & !(DROP_EMPTY & empty);
  assign cnt_inc = burst_cnt + CNT_W'(1);

  for (genvar p = 0; p < RX_PORTS; p++) begin : g_dst
    assign bus.rx_dst_rdy[p] = xfer & (gnt_idx == SEL_W'(p));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.tx_src_rdy <= 1'b0;
      bus.tx_vld     <= '0;
      bus.tx_sel     <= '0;
      bus.tx_data    <= '0;
    end else if (accept) begin
      bus.tx_src_rdy <= wr;
      if (wr) begin
        bus.tx_data <= bus.rx_data[gnt_idx];
        bus.tx_vld  <= bus.rx_vld[gnt_idx];
        bus.tx_sel  <= gnt_idx;
      end
    end
  end

  // Later non-blocking writes override earlier ones: a lock release followed by a
  // same-cycle grant to another port ends up with that port's IDLE handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      lock_port <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      if (lock_hold) begin
        if (wr) begin
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            state     <= IDLE;
            ptr       <= nxt(lock_port);
            burst_cnt <= '0;
          end else begin
            burst_cnt <= cnt_inc;
          end
        end
      end else begin
        if (state == LOCK) begin
          state     <= IDLE;
          ptr       <= nxt(lock_port);
          burst_cnt <= '0;
        end
        if (gnt_vld) begin
          if (MAX_BURST == 1 || !wr) begin
            ptr <= nxt(gnt_idx);
          end else begin
            state     <= LOCK;
            lock_port <= gnt_idx;
            burst_cnt <= CNT_W'(1);
          end
        end
      end
    end
  end
endmodule
